// File: rtl/clock_frequency_divider_pkg.sv
// Shared constants and elaboration-time helpers for the clock divider.
package clk_div_pkg;

  localparam int unsigned DefaultInputFrequency = 50_000_000;

  // Returns 0 for a zero output rate so the top level can flag it instead of dividing by zero.
  function automatic int unsigned half_period(input int unsigned in_hz, input int unsigned out_hz);
    if (out_hz == 0) begin
      return 0;
    end
    return in_hz / (2 * out_hz);
  endfunction

  function automatic int unsigned cnt_width(input int unsigned n);
    if (n <= 2) begin
      return 1;
    end
    return $clog2(n);
  endfunction

endpackage

// File: rtl/clock_frequency_divider_if.sv
// Output bundle of the clock divider; OutTick exists only when CLK_DIV_TICK_EN is defined.
interface clock_frequency_divider_if;

  logic OutClock;
`ifdef CLK_DIV_TICK_EN
  logic OutTick;

  modport master (output OutClock, output OutTick);
  modport slave  (input OutClock, input OutTick);
`else
  modport master (output OutClock);
  modport slave  (input OutClock);
`endif

endinterface

// File: rtl/clock_frequency_divider_mod_counter.sv
// Synchronous-reset modulo counter with a terminal-count flag (tc while count == MODULUS-1).
module mod_counter #(
  parameter int unsigned MODULUS = 2,
  parameter int unsigned W       = 1
) (
  input  logic clk,
  input  logic reset,
  output logic tc
);

  logic [W-1:0] count_q, count_d;

  assign tc = (count_q == W'(MODULUS - 1));

  always_comb begin
    count_d = count_q + W'(1);
    if (tc) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/clock_frequency_divider.sv
// Divides InClock down to a 50% duty OutClock; define CLK_DIV_TICK_EN to add the OutTick strobe.
module clock_frequency_divider
  import clk_div_pkg::*;
#(
  parameter int unsigned INPUT_FREQUENCY  = DefaultInputFrequency,
  parameter int unsigned OUTPUT_FREQUENCY = 10
) (
  input  logic                        InClock,
  input  logic                        reset,
  clock_frequency_divider_if.master   div
);

  localparam int unsigned HALF_PERIOD = half_period(INPUT_FREQUENCY, OUTPUT_FREQUENCY);
  localparam int unsigned CNT_W       = cnt_width(HALF_PERIOD);

  if (OUTPUT_FREQUENCY == 0 || HALF_PERIOD < 1) begin : g_bad_params
    $error("clock_frequency_divider: OUTPUT_FREQUENCY must be nonzero and <= INPUT_FREQUENCY/2");
  end

  logic tc;
  logic out_clock_q;

  mod_counter #(
    .MODULUS (HALF_PERIOD),
    .W       (CNT_W)
  ) u_counter (
    .clk   (InClock),
    .reset (reset),
    .tc    (tc)
  );

  always_ff @(posedge InClock) begin
    if (reset) begin
      out_clock_q <= 1'b0;
    end else if (tc) begin
      out_clock_q <= ~out_clock_q;
    end
  end

  assign div.OutClock = out_clock_q;

`ifdef CLK_DIV_TICK_EN
  logic tick_q;

  // Fires on the same edge that takes OutClock from 0 to 1.
  always_ff @(posedge InClock) begin
    if (reset) begin
      tick_q <= 1'b0;
    end else begin
      tick_q <= tc & ~out_clock_q;
    end
  end

  assign div.OutTick = tick_q;
`endif

endmodule

// File: tb/tb_clock_frequency_divider.sv
// Randomized check of three divider configurations against an edge-count reference model.
module tb_clock_frequency_divider;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  clock_frequency_divider_if if0 ();
  clock_frequency_divider_if if1 ();
  clock_frequency_divider_if if2 ();

  clock_frequency_divider #(.INPUT_FREQUENCY(100), .OUTPUT_FREQUENCY(10)) dut0 (
    .InClock (clk), .reset (rst), .div (if0)
  );
  clock_frequency_divider #(.INPUT_FREQUENCY(20), .OUTPUT_FREQUENCY(10)) dut1 (
    .InClock (clk), .reset (rst), .div (if1)
  );
  clock_frequency_divider #(.INPUT_FREQUENCY(105), .OUTPUT_FREQUENCY(10)) dut2 (
    .InClock (clk), .reset (rst), .div (if2)
  );

  int unsigned n_compared   = 0;
  int unsigned n_mismatched = 0;

  // Half periods worked out by hand: 100/20, 20/20, 105/20 truncated.
  int unsigned hp [3] = '{5, 1, 5};
  // Non-reset edges seen since the last reset edge, per instance.
  int unsigned edges [3];
  int unsigned rises;
  int unsigned cnt_max;
  logic        oc_prev;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic r);
    logic [31:0] oc  [3];
    logic [31:0] cnt [3];
    rst = r;
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      edges[k] = r ? 0 : edges[k] + 1;
    end
    @(negedge clk);
    oc[0]  = 32'(if0.OutClock);
    oc[1]  = 32'(if1.OutClock);
    oc[2]  = 32'(if2.OutClock);
    cnt[0] = 32'(dut0.u_counter.count_q);
    cnt[1] = 32'(dut1.u_counter.count_q);
    cnt[2] = 32'(dut2.u_counter.count_q);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("out_clock[%0d]", k), oc[k], 32'((edges[k] / hp[k]) % 2));
      check($sformatf("counter[%0d]", k), cnt[k], edges[k] % hp[k]);
    end
`ifdef CLK_DIV_TICK_EN
    check("out_tick[0]", 32'(if0.OutTick), 32'(edges[0] % (2 * hp[0]) == hp[0]));
    check("out_tick[1]", 32'(if1.OutTick), 32'(edges[1] % (2 * hp[1]) == hp[1]));
    check("out_tick[2]", 32'(if2.OutTick), 32'(edges[2] % (2 * hp[2]) == hp[2]));
`endif
    if (oc[0][0] && !oc_prev) rises++;
    oc_prev = oc[0][0];
    if (cnt[0] > cnt_max) cnt_max = cnt[0];
  endtask

  initial begin
    oc_prev = 1'b0;
    @(negedge clk);

    // Reset held for three edges, then a free-running stretch of 100 edges.
    repeat (3) step(1'b1);
    rises   = 0;
    cnt_max = 0;
    repeat (100) step(1'b0);
    check("rises_in_100", rises, 10);
    check("counter_max", cnt_max, 4);

    // Reset mid-high-phase: seven edges in OutClock is high and the HP=5 counter sits at 2.
    step(1'b1);
    repeat (7) step(1'b0);
    check("pre_reset_out_clock", 32'(if0.OutClock), 1);
    check("pre_reset_counter", 32'(dut0.u_counter.count_q), 2);
    step(1'b1);
    check("post_reset_out_clock", 32'(if0.OutClock), 0);
    check("post_reset_counter", 32'(dut0.u_counter.count_q), 0);
    rises = 0;
    repeat (4) step(1'b0);
    check("no_rise_before_5", rises, 0);
    step(1'b0);
    check("rise_at_5", rises, 1);

    // Random resets sprinkled over a long run.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 39) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
